// File: rtl/rf_writeback.sv
// rf_writeback: writeback stage in front of the register file.
// Arbitrates between ALU and load results and queues them in an in-order FIFO.
// The queue drains one write per cycle onto the register-file write port and
// exports a per-register pending mask for the hazard logic.
//
// Optional build macro: WB_R0_DISCARD_EN
//   When defined, register 0 is treated as hardwired zero. Results to r0 are
//   still handshaken but never queued, never written, and never pending.
//   When undefined, r0 behaves like any other register.

module rf_writeback #(
    parameter int DATA_W     = 16,
    parameter int REG_AW     = 4,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   alu_valid,
    input  logic [REG_AW-1:0]      alu_rd,
    input  logic [DATA_W-1:0]      alu_data,
    output logic                   alu_ready,

    input  logic                   ld_valid,
    input  logic [REG_AW-1:0]      ld_rd,
    input  logic [DATA_W-1:0]      ld_data,
    output logic                   ld_ready,

    output logic                   rf_wr,
    output logic [REG_AW-1:0]      rf_sel,
    output logic [DATA_W-1:0]      rf_data,

    output logic [(2**REG_AW)-1:0] wb_pending,
    output logic                   wb_empty
);

    localparam int NREG  = 2 ** REG_AW;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [ST_W-1:0]  STARVE_C = ST_W'(STARVE_MAX);

    // Queue bookkeeping
    logic [CNT_W-1:0]  count_q,  count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0]  vld_q,    vld_d;
    logic [ST_W-1:0]   starve_q, starve_d;

    // Queue storage (no reset needed: vld_q qualifies every entry)
    logic [REG_AW-1:0] ent_rd_q   [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];

    // Registered register-file write port
    logic              rf_wr_q,   rf_wr_d;
    logic [REG_AW-1:0] rf_sel_q,  rf_sel_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;

    // Arbitration and handshake results
    logic              space;
    logic              starve_max;
    logic              alu_acc;
    logic              ld_acc;
    logic              push;
    logic              pop;
    logic [REG_AW-1:0] push_rd;
    logic [DATA_W-1:0] push_data;
    logic [NREG-1:0]   pending_c;

    // Select which producer is accepted this cycle; at most one at a time.
    // A pop in the same cycle never frees a slot, so a full queue stalls both.
    always_comb begin
        space      = (count_q < DEPTH_C);
        starve_max = (starve_q == STARVE_C);
        alu_ready  = 1'b0;
        ld_ready   = 1'b0;
        if (!rst && space) begin
            if (alu_valid && ld_valid) begin
                if (starve_max) begin
                    alu_ready = 1'b1;
                end else begin
                    ld_ready = 1'b1;
                end
            end else begin
                alu_ready = !ld_valid;
                ld_ready  = !alu_valid;
            end
        end
    end

    // Resolve the accepted entry and whether it actually enters the queue.
    always_comb begin
        alu_acc   = alu_valid && alu_ready;
        ld_acc    = ld_valid  && ld_ready;
        push_rd   = ld_acc ? ld_rd   : alu_rd;
        push_data = ld_acc ? ld_data : alu_data;
`ifdef WB_R0_DISCARD_EN
        push      = (alu_acc || ld_acc) && (push_rd != '0);
`else
        push      = alu_acc || ld_acc;
`endif
        pop       = (count_q != '0);
    end

    // Count how long an offered ALU result has been losing to the load unit.
    always_comb begin
        starve_d = '0;
        if (alu_valid && !alu_acc) begin
            starve_d = starve_max ? starve_q : starve_q + ST_W'(1);
        end
    end

    // Next-state for pointers, occupancy and the outgoing write.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        vld_d     = vld_q;
        rf_wr_d   = 1'b0;
        rf_sel_d  = rf_sel_q;
        rf_data_d = rf_data_q;

        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PTR_W'(1);
            rf_wr_d         = 1'b1;
            rf_sel_d        = ent_rd_q[rd_ptr_q];
            rf_data_d       = ent_data_q[rd_ptr_q];
        end

        // A push can never hit the slot being popped: that would need the
        // queue to be both empty and full.
        if (push) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state and the write-port register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            vld_q     <= '0;
            starve_q  <= '0;
            rf_wr_q   <= 1'b0;
            rf_sel_q  <= '0;
            rf_data_q <= '0;
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            vld_q     <= vld_d;
            starve_q  <= starve_d;
            rf_wr_q   <= rf_wr_d;
            rf_sel_q  <= rf_sel_d;
            rf_data_q <= rf_data_d;
        end
    end

    // Write the accepted entry into its slot; push is never set during reset.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_rd_q[wr_ptr_q]   <= push_rd;
            ent_data_q[wr_ptr_q] <= push_data;
        end
    end

    // Pending mask: every queued destination plus the write going out now.
    always_comb begin
        pending_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) begin
                pending_c = pending_c | (NREG'(1) << ent_rd_q[i]);
            end
        end
        if (rf_wr_q) begin
            pending_c = pending_c | (NREG'(1) << rf_sel_q);
        end
`ifdef WB_R0_DISCARD_EN
        pending_c[0] = 1'b0;
`endif
    end

    assign rf_wr      = rf_wr_q;
    assign rf_sel     = rf_sel_q;
    assign rf_data    = rf_data_q;
    assign wb_pending = pending_c;
    assign wb_empty   = (count_q == '0) && !rf_wr_q;

endmodule
